// File: rtl/turn_signal_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// car_pkg
// Shared definitions for the turn-signal controller and the blocks that work
// alongside it (sound unit, lamp drivers, dashboard).
//
// Contents:
//   turn_state_t              - turn-signal controller state
//   CLK_HZ                    - system clock frequency
//   DEFAULT_DEBOUNCE_CYCLES   - switch settle time in clocks (20 ms)
//   DEFAULT_BLINK_HALF_CYCLES - lamp ON/OFF phase length in clocks (0.4 s)
//   counterWidth()            - bits needed to count 0..count-1
// ----------------------------------------------------------------------------
package car_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LEFT   = 2'd1,
        ST_RIGHT  = 2'd2,
        ST_HAZARD = 2'd3
    } turn_state_t;

    localparam int CLK_HZ                    = 50_000_000;
    localparam int DEFAULT_DEBOUNCE_CYCLES   = 1_000_000;
    localparam int DEFAULT_BLINK_HALF_CYCLES = 20_000_000;

    // A counter that runs 0..count-1 needs ceil(log2(count)) bits; a count of
    // one still gets a single bit so the vector never collapses to zero width.
    function automatic int counterWidth(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/turn_signal_ctrl_if.sv
// ----------------------------------------------------------------------------
// turn_signal_ctrl_if
// Bundles the driver switch inputs and the lamp / sound / dashboard outputs of
// the turn-signal controller.
//
// Signals:
//   engine_on       - engine running, already synchronous to clk
//   lever_left_raw  - raw lever-left contact (asynchronous, bouncy)
//   lever_right_raw - raw lever-right contact (asynchronous, bouncy)
//   hazard_btn_raw  - raw momentary hazard button (asynchronous, bouncy)
//   left_lamp       - left indicator lamp drive
//   right_lamp      - right indicator lamp drive
//   turn_signal_on  - blink phase for the sound unit, 0 when idle
//   hazard_active   - hazard latch state for the dashboard LED
//
// Modports:
//   master - the switch side / environment: drives inputs, observes outputs
//   slave  - the controller itself
// ----------------------------------------------------------------------------
interface turn_signal_ctrl_if;

    logic engine_on;
    logic lever_left_raw;
    logic lever_right_raw;
    logic hazard_btn_raw;
    logic left_lamp;
    logic right_lamp;
    logic turn_signal_on;
    logic hazard_active;

    modport master (
        output engine_on,
        output lever_left_raw,
        output lever_right_raw,
        output hazard_btn_raw,
        input  left_lamp,
        input  right_lamp,
        input  turn_signal_on,
        input  hazard_active
    );

    modport slave (
        input  engine_on,
        input  lever_left_raw,
        input  lever_right_raw,
        input  hazard_btn_raw,
        output left_lamp,
        output right_lamp,
        output turn_signal_on,
        output hazard_active
    );

endinterface

// File: rtl/turn_signal_ctrl_sw_debounce.sv
// ----------------------------------------------------------------------------
// sw_debounce
// Conditions one raw mechanical switch contact: a two-flop synchroniser
// followed by a stability counter. The debounced level only changes after the
// synchronised input has disagreed with it for DEBOUNCE_CYCLES consecutive
// clocks, so any glitch shorter than that is swallowed.
//
// Ports:
//   clk     - system clock
//   rst     - asynchronous, active-high reset
//   i_raw   - raw switch contact, asynchronous to clk
//   o_level - debounced, clk-synchronous switch level
// ----------------------------------------------------------------------------
module sw_debounce
    import car_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int             CW       = counterWidth(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_count;
    logic          r_level;

    // Two-flop synchroniser; the first stage may go metastable and is never
    // looked at by anything except the second stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Stability counter: any cycle where the synchronised input agrees with the
    // accepted level restarts the count. The flip happens on the edge that sees
    // the DEBOUNCE_CYCLES-th consecutive disagreeing sample, and the counter
    // clears at the same time so the new level starts from a clean slate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_level <= 1'b0;
        end else if (r_sync2 == r_level) begin
            r_count <= '0;
        end else if (r_count == CNT_LAST) begin
            r_count <= '0;
            r_level <= r_sync2;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/turn_signal_ctrl.sv
// ----------------------------------------------------------------------------
// turn_signal_ctrl
// Turns the turn-signal lever and the hazard button into left/right lamp
// drives, a blink-phase signal for the sound unit (which clicks on each edge)
// and a hazard indicator for the dashboard.
//
// Ports:
//   clk - 50 MHz system clock
//   rst - asynchronous, active-high reset
//   bus - turn_signal_ctrl_if.slave: engine_on and the three raw switch
//         contacts in; left_lamp, right_lamp, turn_signal_on, hazard_active out
//
// Parameters:
//   DEBOUNCE_CYCLES   - stable clocks before a switch change is accepted
//   BLINK_HALF_CYCLES - clocks per lamp ON phase and per OFF phase
// ----------------------------------------------------------------------------
module turn_signal_ctrl
    import car_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int BLINK_HALF_CYCLES = DEFAULT_BLINK_HALF_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    turn_signal_ctrl_if.slave    bus
);

    localparam int             TW         = counterWidth(BLINK_HALF_CYCLES);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(BLINK_HALF_CYCLES - 1);

    logic          w_leftDb;
    logic          w_rightDb;
    logic          w_hazardDb;
    logic          w_leverLeft;
    logic          w_leverRight;
    logic          w_hazardRise;

    logic          r_hazardDbPrev;
    logic          r_hazardLatch;

    turn_state_t   r_state;
    turn_state_t   w_nextState;
    logic          r_phase;
    logic [TW-1:0] r_timer;

    logic          w_leftLampNext;
    logic          w_rightLampNext;
    logic          w_turnOnNext;
    logic          r_leftLamp;
    logic          r_rightLamp;
    logic          r_turnOn;
    logic          r_hazardActive;

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debLeft (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (bus.lever_left_raw),
        .o_level (w_leftDb)
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debRight (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (bus.lever_right_raw),
        .o_level (w_rightDb)
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debHazard (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (bus.hazard_btn_raw),
        .o_level (w_hazardDb)
    );

    // Both lever contacts closed at once can only be a contact fault, so that
    // combination counts as neither direction.
    assign w_leverLeft  = w_leftDb  & ~w_rightDb;
    assign w_leverRight = w_rightDb & ~w_leftDb;
    assign w_hazardRise = w_hazardDb & ~r_hazardDbPrev;

    // The hazard button is momentary: each press toggles the latch and the
    // release is ignored. Engine state plays no part here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hazardDbPrev <= 1'b0;
            r_hazardLatch  <= 1'b0;
        end else begin
            r_hazardDbPrev <= w_hazardDb;
            if (w_hazardRise) begin
                r_hazardLatch <= ~r_hazardLatch;
            end
        end
    end

    // State register for the turn-signal FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state is re-derived from scratch every cycle rather than from the
    // current state: hazard wins, then a lever direction if the engine runs.
    always_comb begin
        w_nextState = ST_IDLE;
        if (r_hazardLatch) begin
            w_nextState = ST_HAZARD;
        end else if (bus.engine_on && w_leverLeft) begin
            w_nextState = ST_LEFT;
        end else if (bus.engine_on && w_leverRight) begin
            w_nextState = ST_RIGHT;
        end
    end

    // Blink phase generator. Any move into an active state restarts the
    // pattern lit with a fresh timer, so the driver always sees an immediate
    // flash (this also covers LEFT<->RIGHT and hazard on/off transitions).
    // While the state holds, the timer runs 0..BLINK_HALF_CYCLES-1 and the
    // phase toggles on every wrap. IDLE parks everything at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= 1'b0;
            r_timer <= '0;
        end else if (w_nextState == ST_IDLE) begin
            r_phase <= 1'b0;
            r_timer <= '0;
        end else if (w_nextState != r_state) begin
            r_phase <= 1'b1;
            r_timer <= '0;
        end else if (r_timer == TIMER_LAST) begin
            r_phase <= ~r_phase;
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // Lamp and sound decode from the current state and phase.
    always_comb begin
        w_leftLampNext  = 1'b0;
        w_rightLampNext = 1'b0;
        w_turnOnNext    = 1'b0;
        case (r_state)
            ST_LEFT: begin
                w_leftLampNext  = r_phase;
                w_turnOnNext    = r_phase;
            end
            ST_RIGHT: begin
                w_rightLampNext = r_phase;
                w_turnOnNext    = r_phase;
            end
            ST_HAZARD: begin
                w_leftLampNext  = r_phase;
                w_rightLampNext = r_phase;
                w_turnOnNext    = r_phase;
            end
            default: begin
                w_leftLampNext  = 1'b0;
                w_rightLampNext = 1'b0;
                w_turnOnNext    = 1'b0;
            end
        endcase
    end

    // Outputs are registered so the lamp drivers and sound unit see glitch-free
    // levels; the asynchronous reset still darkens them immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_leftLamp     <= 1'b0;
            r_rightLamp    <= 1'b0;
            r_turnOn       <= 1'b0;
            r_hazardActive <= 1'b0;
        end else begin
            r_leftLamp     <= w_leftLampNext;
            r_rightLamp    <= w_rightLampNext;
            r_turnOn       <= w_turnOnNext;
            r_hazardActive <= r_hazardLatch;
        end
    end

    assign bus.left_lamp      = r_leftLamp;
    assign bus.right_lamp     = r_rightLamp;
    assign bus.turn_signal_on = r_turnOn;
    assign bus.hazard_active  = r_hazardActive;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// ----------------------------------------------------------------------------
// tb_turn_signal_ctrl
// Self-checking bench for turn_signal_ctrl with short debounce and blink
// times. A behavioural model predicts all four outputs every cycle; a few
// directed measurements (latency, reset, engine-off) are checked on top.
// ----------------------------------------------------------------------------
module tb_turn_signal_ctrl;

    localparam int N    = 4;
    localparam int HALF = 10;
    localparam int HIST = N + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checkCount = 0;
    int errorCount = 0;
    bit checkEn    = 1'b0;

    turn_signal_ctrl_if tsIf ();

    turn_signal_ctrl #(
        .DEBOUNCE_CYCLES   (N),
        .BLINK_HALF_CYCLES (HALF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (tsIf.slave)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Drives all switch inputs at a falling edge and holds them for a number of
    // cycles, returning on a falling edge.
    task automatic applyStimulus(input bit eng, input bit lft, input bit rgt,
                                 input bit haz, input int cycles);
        tsIf.engine_on       = eng;
        tsIf.lever_left_raw  = lft;
        tsIf.lever_right_raw = rgt;
        tsIf.hazard_btn_raw  = haz;
        repeat (cycles) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Reference model. Raw samples are kept as a short history per input; a
    // switch is accepted once the samples that have reached the debouncer
    // show an unbroken run of N opposite values. The blink phase is derived
    // from how long the controller has been in its current state.
    // ------------------------------------------------------------------
    bit [HIST-1:0] mHist [3];
    bit            mDeb  [3];
    bit            mRaw  [3];
    bit            mDebHazPrev;
    bit            mLatch;
    int            mState;
    int            mNext;
    int            mAge;
    bit            mPhase;
    bit            mLeverL;
    bit            mLeverR;
    bit            mLeft;
    bit            mRight;
    bit            mTurn;
    bit            mHaz;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mHist[i] = '0;
                mDeb[i]  = 1'b0;
            end
            mDebHazPrev = 1'b0;
            mLatch      = 1'b0;
            mState      = 0;
            mAge        = 0;
            mPhase      = 1'b0;
            mLeft       = 1'b0;
            mRight      = 1'b0;
            mTurn       = 1'b0;
            mHaz        = 1'b0;
        end else begin
            mRaw[0] = tsIf.lever_left_raw;
            mRaw[1] = tsIf.lever_right_raw;
            mRaw[2] = tsIf.hazard_btn_raw;

            // 0 idle, 1 left, 2 right, 3 hazard
            mLeft  = mPhase && (mState == 1 || mState == 3);
            mRight = mPhase && (mState == 2 || mState == 3);
            mTurn  = mPhase && (mState != 0);
            mHaz   = mLatch;

            mLeverL = mDeb[0] && !mDeb[1];
            mLeverR = mDeb[1] && !mDeb[0];
            if (mLatch)                         mNext = 3;
            else if (tsIf.engine_on && mLeverL) mNext = 1;
            else if (tsIf.engine_on && mLeverR) mNext = 2;
            else                                mNext = 0;

            if (mNext != mState) mAge = 0;
            else                 mAge = mAge + 1;
            mPhase = (mNext != 0) && (((mAge / HALF) % 2) == 0);
            mState = mNext;

            mLatch      = mLatch ^ (mDeb[2] && !mDebHazPrev);
            mDebHazPrev = mDeb[2];

            for (int i = 0; i < 3; i++) begin
                mHist[i] = {mHist[i][HIST-2:0], mRaw[i]};
                if (mHist[i][HIST-1:2] == {N{~mDeb[i]}}) mDeb[i] = ~mDeb[i];
            end
        end
    end

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("left_lamp",      tsIf.left_lamp,      mLeft);
            checkOutput("right_lamp",     tsIf.right_lamp,     mRight);
            checkOutput("turn_signal_on", tsIf.turn_signal_on, mTurn);
            checkOutput("hazard_active",  tsIf.hazard_active,  mHaz);
        end
    end

    int riseEdge;
    bit seenOn;
    bit seenOff;

    initial begin
        tsIf.engine_on       = 1'b0;
        tsIf.lever_left_raw  = 1'b0;
        tsIf.lever_right_raw = 1'b0;
        tsIf.hazard_btn_raw  = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_left",   tsIf.left_lamp,      0);
        checkOutput("reset_right",  tsIf.right_lamp,     0);
        checkOutput("reset_turn",   tsIf.turn_signal_on, 0);
        checkOutput("reset_hazard", tsIf.hazard_active,  0);
        rst     = 1'b0;
        checkEn = 1'b1;

        $display("[TB] idle with engine running");
        applyStimulus(1, 0, 0, 0, 10);

        $display("[TB] bounce rejection");
        for (int g = 0; g < 3; g++) begin
            applyStimulus(1, 1, 0, 0, 3);
            applyStimulus(1, 0, 0, 0, 3);
        end
        applyStimulus(1, 0, 0, 0, 10);
        checkOutput("bounce_left_quiet", tsIf.left_lamp, 0);

        $display("[TB] left blink latency");
        tsIf.lever_left_raw = 1'b1;
        riseEdge = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (tsIf.left_lamp && riseEdge == 0) riseEdge = e;
        end
        checkOutput("left_rise_edge", riseEdge, N + 4);
        @(negedge clk);
        applyStimulus(1, 1, 0, 0, 30);

        $display("[TB] switch left to right during off phase");
        seenOn  = 1'b0;
        seenOff = 1'b0;
        for (int w = 0; w < 4 * HALF && !seenOff; w++) begin
            if (tsIf.left_lamp) seenOn = 1'b1;
            else if (seenOn)    seenOff = 1'b1;
            if (!seenOff) @(negedge clk);
        end
        checkOutput("wait_left_off", seenOff, 1);
        tsIf.lever_left_raw  = 1'b0;
        tsIf.lever_right_raw = 1'b1;
        riseEdge = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (tsIf.right_lamp && riseEdge == 0) riseEdge = e;
        end
        checkOutput("right_rise_edge", riseEdge, N + 4);
        @(negedge clk);
        applyStimulus(1, 0, 1, 0, 15);

        $display("[TB] engine off during right");
        tsIf.engine_on = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("engine_off_right", tsIf.right_lamp,     0);
        checkOutput("engine_off_turn",  tsIf.turn_signal_on, 0);
        @(negedge clk);
        applyStimulus(0, 0, 1, 0, 5);

        $display("[TB] hazard from left");
        applyStimulus(1, 1, 0, 0, 30);
        applyStimulus(1, 1, 0, 1, 6);
        applyStimulus(0, 1, 0, 0, 40);
        checkOutput("hazard_on", tsIf.hazard_active, 1);
        applyStimulus(0, 1, 0, 1, 6);
        applyStimulus(0, 1, 0, 0, 20);
        checkOutput("hazard_off",       tsIf.hazard_active, 0);
        checkOutput("hazard_off_left",  tsIf.left_lamp,     0);
        checkOutput("hazard_off_right", tsIf.right_lamp,    0);

        $display("[TB] both levers");
        applyStimulus(1, 1, 1, 0, 25);
        checkOutput("both_left",  tsIf.left_lamp,  0);
        checkOutput("both_right", tsIf.right_lamp, 0);

        $display("[TB] reset mid-blink");
        applyStimulus(1, 1, 0, 0, 14);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_left",   tsIf.left_lamp,      0);
        checkOutput("midrst_right",  tsIf.right_lamp,     0);
        checkOutput("midrst_turn",   tsIf.turn_signal_on, 0);
        checkOutput("midrst_hazard", tsIf.hazard_active,  0);
        @(negedge clk);
        applyStimulus(1, 0, 0, 0, 2);
        rst = 1'b0;
        applyStimulus(1, 0, 0, 0, 15);
        checkOutput("after_rst_left", tsIf.left_lamp, 0);

        $display("[TB] randomized stimulus");
        for (int k = 0; k < 1500; k++) begin
            applyStimulus(($urandom_range(0, 7) != 0),
                          $urandom_range(0, 1),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 7) == 0),
                          $urandom_range(1, 12));
        end

        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
